sm_trace_buffer: RTL and testbench
==================================

SM_TRACE_BUFFER -- requirements
Module: sm_trace_buffer

Interface
REQ-001 Parameter DEPTH, default 16: number of trace entries; power of two, at least 2.
REQ-002 Parameter POST, default 4: entries captured after the trigger entry; range 0..DEPTH-1.
REQ-003 Reset is synchronous and active-high; the block uses one clock.
REQ-004 clk  in  1  CPU clock; all state changes on its rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 arm  in  1  one-cycle pulse that clears the buffer and starts capture.
REQ-007 cap_valid  in  1  the CPU retires one instruction this cycle.
REQ-008 cap_pc  in  32  pc of the retiring instruction.
REQ-009 cap_instr  in  32  instruction word of the retiring instruction.
REQ-010 trig_pc  in  32  trigger address; held stable while armed.
REQ-011 rd_ready  in  1  consumer accepts the current read entry.
REQ-012 rd_valid  out  1  an entry is presented on rd_pc and rd_instr.
REQ-013 rd_pc  out  32  pc of the oldest unread entry.
REQ-014 rd_instr  out  32  instruction word of the oldest unread entry.
REQ-015 count  out  log2(DEPTH)+1  number of valid entries held.
REQ-016 wrapped  out  1  one or more entries were overwritten since the last arm.
REQ-017 busy  out  1  high in ARMED or POST.
REQ-018 done  out  1  high in DRAIN.

Function
REQ-019 The block SHALL have four states: IDLE, ARMED, POST and DRAIN.
REQ-020 Storage SHALL be a circular array indexed by wr_ptr with log2(DEPTH) bits; all pointer arithmetic SHALL wrap modulo DEPTH.
REQ-021 An arm pulse in any state SHALL, on the next clock edge, clear wr_ptr, count and wrapped and move the block to ARMED.
REQ-022 When arm and cap_valid are both high in the same cycle, arm SHALL take priority and no entry is written that cycle.
REQ-023 In ARMED or POST, each cycle with cap_valid high SHALL write {cap_pc, cap_instr} at wr_ptr and increment wr_ptr.
REQ-024 Each such write SHALL increment count, which saturates at DEPTH.
REQ-025 A write made while count equals DEPTH SHALL set wrapped, and the oldest entry is lost.
REQ-026 In IDLE and DRAIN, cap_valid SHALL be ignored.
REQ-027 In ARMED, a cycle with cap_valid high and cap_pc equal to trig_pc SHALL write that entry and load post_cnt with POST.
REQ-028 After such a trigger write, the block SHALL go to POST when POST is non-zero, or straight to DRAIN when POST is zero.
REQ-029 In POST, each write SHALL decrement post_cnt; the write that brings post_cnt to 0 SHALL move the block to DRAIN.
REQ-030 A second trig_pc match while in POST SHALL have no trigger effect.
REQ-031 The read pointer SHALL be computed combinationally as wr_ptr minus count, modulo DEPTH.
REQ-032 rd_pc and rd_instr SHALL come combinationally from the array entry at the read pointer.
REQ-033 rd_valid SHALL equal (state is DRAIN) AND (count is non-zero).
REQ-034 A cycle with rd_valid and rd_ready both high SHALL decrement count by 1 on the next edge.
REQ-035 The handshake that brings count to 0 SHALL return the block to IDLE.
REQ-036 While rd_ready is low, rd_valid, rd_pc and rd_instr SHALL hold their values.
REQ-037 Entering DRAIN with count equal to 0 cannot occur, because the trigger entry is always written.
REQ-038 There SHALL be no timeout: the block stays in ARMED until a match or an arm pulse.

Reset
REQ-039 When rst is high at a clock edge, the block SHALL go to IDLE.
REQ-040 The same reset edge SHALL clear wr_ptr, count, post_cnt and wrapped.
REQ-041 After reset, rd_valid, busy, done and wrapped SHALL read 0, count SHALL read 0, and rd_pc and rd_instr SHALL be don't-care.
REQ-042 rst SHALL override arm and cap_valid, including reset in the middle of POST or DRAIN.
REQ-043 Array contents need not be reset.

Verification (DEPTH=16, POST=4)
REQ-044 Reset: hold rst 2 cycles with arm and cap_valid high -> count=0, busy=0, done=0, rd_valid=0.
REQ-045 Basic capture: arm, trig_pc=0x10, 9 consecutive writes with pc 0x00..0x20 step 4 -> DRAIN after the 9th write, count=9, wrapped=0.
REQ-046 Basic readout: from the REQ-045 state with rd_ready=1 -> reads pc 0x00..0x20 in order, then IDLE.
REQ-047 Wrap: trig_pc=0x100, 20 writes pc 0x00..0x4C, then pc 0x100, then 4 more writes -> count=16, wrapped=1.
REQ-048 Wrap readout: from the REQ-047 state -> first rd_pc=0x24, last rd_pc is the 4th post-trigger entry.
REQ-049 Backpressure: in DRAIN, rd_ready=0 for 5 cycles -> rd_valid=1, rd_pc unchanged, count unchanged; on rd_ready=1, one entry advances per cycle.
REQ-050 Re-arm in POST, and cap_valid gating: arm asserted mid-POST -> next cycle ARMED with count=0; trig_pc presented with cap_valid=0 -> no write, state stays ARMED; arm together with cap_valid -> no write that cycle.

Source files
------------

// File: rtl/sm_trace_buffer_if.sv
// Bundle of the capture, trigger and readout signals of the instruction trace buffer.
// The master side feeds retired instructions and drains entries; the slave side is the buffer.
interface sm_trace_buffer_if #(
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          arm;
  logic          cap_valid;
  logic [31:0]   cap_pc;
  logic [31:0]   cap_instr;
  logic [31:0]   trig_pc;
  logic          rd_ready;
  logic          rd_valid;
  logic [31:0]   rd_pc;
  logic [31:0]   rd_instr;
  logic [CW-1:0] count;
  logic          wrapped;
  logic          busy;
  logic          done;

  modport master (
    output arm, cap_valid, cap_pc, cap_instr, trig_pc, rd_ready,
    input  rd_valid, rd_pc, rd_instr, count, wrapped, busy, done
  );

  modport slave (
    input  arm, cap_valid, cap_pc, cap_instr, trig_pc, rd_ready,
    output rd_valid, rd_pc, rd_instr, count, wrapped, busy, done
  );
endinterface

// File: rtl/sm_trace_buffer.sv
// Circular instruction trace buffer: captures retired pc/instr pairs until a trigger pc
// plus POST further entries, then drains oldest-first over a valid/ready port.
module sm_trace_buffer #(
  parameter int DEPTH = 16,
  parameter int POST  = 4
) (
  input  logic clk,
  input  logic rst,
  sm_trace_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    POST_ST = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] post_cnt_q, post_cnt_d;
  logic          wrapped_q, wrapped_d;
  logic          wr_en;
  logic [AW-1:0] rd_ptr;
  logic          rd_valid;

  logic [63:0]   mem [DEPTH];

  // Oldest entry sits count slots behind the write pointer; a full buffer wraps onto wr_ptr.
  assign rd_ptr   = wr_ptr_q - count_q[AW-1:0];
  assign rd_valid = (state_q == DRAIN) && (count_q != '0);

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    post_cnt_d = post_cnt_q;
    wrapped_d  = wrapped_q;
    wr_en      = 1'b0;

    if (bus.arm) begin
      state_d    = ARMED;
      wr_ptr_d   = '0;
      count_d    = '0;
      post_cnt_d = '0;
      wrapped_d  = 1'b0;
    end else begin
      case (state_q)
        ARMED: begin
          if (bus.cap_valid) begin
            wr_en = 1'b1;
            if (bus.cap_pc == bus.trig_pc) begin
              post_cnt_d = AW'(POST);
              state_d    = (POST == 0) ? DRAIN : POST_ST;
            end
          end
        end
        POST_ST: begin
          if (bus.cap_valid) begin
            wr_en      = 1'b1;
            post_cnt_d = post_cnt_q - 1'b1;
            if (post_cnt_q == AW'(1)) state_d = DRAIN;
          end
        end
        DRAIN: begin
          if (rd_valid && bus.rd_ready) begin
            count_d = count_q - 1'b1;
            if (count_q == CW'(1)) state_d = IDLE;
          end
        end
        default: ;
      endcase

      if (wr_en) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        if (count_q == CW'(DEPTH)) wrapped_d = 1'b1;
        else                       count_d   = count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      post_cnt_q <= '0;
      wrapped_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      post_cnt_q <= post_cnt_d;
      wrapped_q  <= wrapped_d;
    end
  end

  // Storage is not reset; stale entries are never presented because count gates them.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) mem[wr_ptr_q] <= {bus.cap_pc, bus.cap_instr};
  end

  assign bus.rd_valid = rd_valid;
  assign bus.rd_pc    = mem[rd_ptr][63:32];
  assign bus.rd_instr = mem[rd_ptr][31:0];
  assign bus.count    = count_q;
  assign bus.wrapped  = wrapped_q;
  assign bus.busy     = (state_q == ARMED) || (state_q == POST_ST);
  assign bus.done     = (state_q == DRAIN);
endmodule

// File: tb/tb_sm_trace_buffer.sv
// Directed and randomized checks of sm_trace_buffer against a queue-based model of the
// capture/trigger/drain behaviour.
module tb_sm_trace_buffer;
  localparam int DEPTH = 16;
  localparam int POST  = 4;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  sm_trace_buffer_if #(.DEPTH(DEPTH)) bus ();

  sm_trace_buffer #(.DEPTH(DEPTH), .POST(POST)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  typedef enum {M_IDLE, M_ARMED, M_POST, M_DRAIN} mstate_t;

  ent_t        mq[$];
  mstate_t     m_state;
  int          m_post;
  logic        m_wrapped;
  logic [31:0] trig_v;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_update(input logic r, input logic a, input logic cv,
                              input logic [31:0] pc, input logic [31:0] ins, input logic rdy);
    ent_t e;
    if (r) begin
      m_state = M_IDLE; mq.delete(); m_wrapped = 1'b0; m_post = 0;
    end else if (a) begin
      m_state = M_ARMED; mq.delete(); m_wrapped = 1'b0;
    end else begin
      if ((m_state == M_ARMED || m_state == M_POST) && cv) begin
        e.pc = pc; e.instr = ins;
        mq.push_back(e);
        if (mq.size() > DEPTH) begin
          void'(mq.pop_front());
          m_wrapped = 1'b1;
        end
        if (m_state == M_ARMED) begin
          if (pc == trig_v) begin
            m_post  = POST;
            m_state = (POST == 0) ? M_DRAIN : M_POST;
          end
        end else begin
          m_post--;
          if (m_post == 0) m_state = M_DRAIN;
        end
      end else if (m_state == M_DRAIN && mq.size() > 0 && rdy) begin
        void'(mq.pop_front());
        if (mq.size() == 0) m_state = M_IDLE;
      end
    end
  endtask

  task automatic check_all();
    logic exp_rv;
    exp_rv = (m_state == M_DRAIN) && (mq.size() > 0);
    chk("count",    32'(bus.count), 32'(mq.size()));
    chk("wrapped",  32'(bus.wrapped), 32'(m_wrapped));
    chk("busy",     32'(bus.busy), 32'(m_state == M_ARMED || m_state == M_POST));
    chk("done",     32'(bus.done), 32'(m_state == M_DRAIN));
    chk("rd_valid", 32'(bus.rd_valid), 32'(exp_rv));
    if (exp_rv) begin
      chk("rd_pc",    bus.rd_pc, mq[0].pc);
      chk("rd_instr", bus.rd_instr, mq[0].instr);
    end
  endtask

  task automatic step(input logic r, input logic a, input logic cv,
                      input logic [31:0] pc, input logic [31:0] ins, input logic rdy);
    rst           = r;
    bus.arm       = a;
    bus.cap_valid = cv;
    bus.cap_pc    = pc;
    bus.cap_instr = ins;
    bus.rd_ready  = rdy;
    bus.trig_pc   = trig_v;
    @(posedge clk);
    model_update(r, a, cv, pc, ins, rdy);
    #1;
    check_all();
  endtask

  initial begin
    logic [31:0] held_pc;
    logic [31:0] last_pc;
    total = 0; bad = 0;
    trig_v = 32'h10;
    m_state = M_IDLE; m_post = 0; m_wrapped = 1'b0;
    rst = 1'b1; bus.arm = 1'b1; bus.cap_valid = 1'b1; bus.cap_pc = '0;
    bus.cap_instr = '0; bus.rd_ready = 1'b0; bus.trig_pc = trig_v;

    // Reset overrides arm and cap_valid
    step(1, 1, 1, 32'h10, 32'h1, 0);
    step(1, 1, 1, 32'h10, 32'h2, 0);
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_busy",  32'(bus.busy), 32'd0);
    chk("rst_done",  32'(bus.done), 32'd0);
    chk("rst_rv",    32'(bus.rd_valid), 32'd0);

    // Basic capture: trigger on the 5th write, 4 post entries
    step(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) step(0, 0, 1, 32'(i * 4), $urandom, 0);
    chk("cap_done",    32'(bus.done), 32'd1);
    chk("cap_count",   32'(bus.count), 32'd9);
    chk("cap_wrapped", 32'(bus.wrapped), 32'd0);
    step(0, 0, 1, 32'h10, 32'h0, 0);
    chk("drain_ignores_cap", 32'(bus.count), 32'd9);

    // Basic readout in order
    for (int i = 0; i < 9; i++) begin
      chk("read_order", bus.rd_pc, 32'(i * 4));
      step(0, 0, 0, 0, 0, 1);
    end
    chk("read_idle_done", 32'(bus.done), 32'd0);
    chk("read_idle_rv",   32'(bus.rd_valid), 32'd0);

    // Wrap: 20 writes, trigger, 4 post writes
    trig_v = 32'h100;
    step(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) step(0, 0, 1, 32'(i * 4), $urandom, 0);
    step(0, 0, 1, 32'h100, $urandom, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 32'h200 + 32'(i * 4), $urandom, 0);
    chk("wrap_count",   32'(bus.count), 32'd16);
    chk("wrap_flag",    32'(bus.wrapped), 32'd1);
    chk("wrap_first",   bus.rd_pc, 32'h24);

    // Backpressure for 5 cycles, then drain one per cycle
    held_pc = 32'h24;
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0, 0, 0);
      chk("bp_rv",    32'(bus.rd_valid), 32'd1);
      chk("bp_pc",    bus.rd_pc, held_pc);
      chk("bp_count", 32'(bus.count), 32'd16);
    end
    last_pc = '0;
    for (int i = 0; i < 16; i++) begin
      chk("drain_count", 32'(bus.count), 32'(16 - i));
      last_pc = bus.rd_pc;
      step(0, 0, 0, 0, 0, 1);
    end
    chk("wrap_last", last_pc, 32'h20C);
    chk("wrap_idle", 32'(bus.done), 32'd0);

    // Re-arm in POST and cap_valid gating
    trig_v = 32'h40;
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 1, 32'h3C, $urandom, 0);
    step(0, 0, 1, 32'h40, $urandom, 0);
    step(0, 0, 1, 32'h44, $urandom, 0);
    chk("post_count", 32'(bus.count), 32'd3);
    step(0, 1, 1, 32'h48, $urandom, 0);
    chk("rearm_count", 32'(bus.count), 32'd0);
    chk("rearm_busy",  32'(bus.busy), 32'd1);
    step(0, 0, 0, 32'h40, $urandom, 0);
    chk("gate_count", 32'(bus.count), 32'd0);
    chk("gate_busy",  32'(bus.busy), 32'd1);
    chk("gate_done",  32'(bus.done), 32'd0);
    step(0, 1, 1, 32'h40, $urandom, 0);
    chk("arm_cv_count", 32'(bus.count), 32'd0);
    chk("arm_cv_busy",  32'(bus.busy), 32'd1);

    // Randomized traffic with occasional arm, reset and trigger matches
    for (int n = 0; n < 3000; n++) begin
      logic        r, a, cv, rdy;
      logic [31:0] pc;
      r   = ($urandom_range(0, 299) == 0);
      a   = ($urandom_range(0, 59) == 0);
      cv  = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 2) != 0);
      pc  = ($urandom_range(0, 24) == 0) ? trig_v : {$urandom_range(0, 255), 2'b00};
      if (pc == trig_v && $urandom_range(0, 1) == 0) pc = pc + 32'h4;
      step(r, a, cv, pc, $urandom, rdy);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
